pe_feeder: RTL and testbench
============================

// Module: pe_feeder
// PURPOSE
//  Transmit side of the PE operand interface. Accepts one job command (vector length K, vector count N)
//  and merges two streaming sources, A and B, into paired writes to a PE's afifo/bfifo.
//  Issues the start pulse and the max_cntr value to the PE.
//  Counts the PE's se pulses and signals job completion. Sits between the operand buffers and pe column 0.
// PARAMETERS
//  DW      16  operand width (a_in/b_in)
//  LW      8   vector-length field width (max_cntr)
//  CW      16  vector-count width
// PORTS
//  clk         in   1    clock
//  rst_n       in   1    reset, asynchronous, active-low
//  cmd_valid   in   1    job request
//  cmd_ready   out  1    high only in IDLE
//  cmd_len     in   LW   K-1; elements per dot product (0 -> K=1)
//  cmd_cnt     in   CW   N; dot products in this job
//  a_src_valid in   1    A stream word available
//  a_src_data  in   DW   A stream word
//  a_src_ready out  1    A word consumed (= push)
//  b_src_valid in   1    B stream word available
//  b_src_data  in   DW   B stream word
//  b_src_ready out  1    B word consumed (= push)
//  halt        in   1    host pause request
//  aff         in   1    PE afifo full
//  bff         in   1    PE bfifo full
//  se          in   1    PE sum-end pulse, one per finished dot product
//  a_in        out  DW   to PE afifo
//  b_in        out  DW   to PE bfifo
//  awe         out  1    afifo write
//  bwe         out  1    bfifo write
//  ais         out  1    PE pipeline suspend, A side
//  bis         out  1    PE pipeline suspend, B side
//  start       out  1    one-cycle job start to PE
//  max_cntr    out  LW   latched cmd_len, held for the whole job
//  busy        out  1    state != IDLE
//  done        out  1    one-cycle pulse at job completion
// BEHAVIOUR
//  Reset: every register and output is 0. state=IDLE. cmd_ready is 1 from the first cycle after reset.
//  FSM states: IDLE, START, STREAM, WAIT, DONE.
//   IDLE:   on cmd_valid (cmd_ready=1): latch len/cnt, total=N*(K) pairs (CW+LW bits), se_cnt=0.
//           If N==0 -> DONE. Else -> START.
//   START:  start=1 for exactly this cycle; max_cntr already valid. -> STREAM.
//   STREAM: push = a_src_valid & b_src_valid & ~aff & ~bff & ~halt_q & (pairs_left!=0).
//           When push: awe=bwe=a_src_ready=b_src_ready=1; a_in=a_src_data, b_in=b_src_data.
//           All of these are combinational, same cycle, zero latency. A and B are never written separately.
//           pairs_left decrements on push. On the last push -> WAIT.
//   WAIT:   no pushes. -> DONE when se_cnt reaches N.
//   DONE:   done=1 for one cycle. -> IDLE.
//  se_cnt increments on se in START/STREAM/WAIT and saturates at N. se in IDLE/DONE is ignored.
//  halt_q is halt registered one cycle. ais=bis=halt_q in every state except IDLE.
//   While halt_q=1: no pushes. Counters hold. start is not delayed if already in START.
//  Full flags are sampled in the push cycle. If aff or bff is set, neither source is consumed.
//  max_cntr stays unchanged from IDLE accept through DONE. It returns to 0 only on reset.
//  cmd_valid outside IDLE is ignored; cmd_ready=0.
//  Reset mid-job aborts immediately: no done pulse; outputs 0.
// STRUCTURE
//  Shared package sys_pkg:
//   - feeder state enum (3-bit encoding)
//   - DW/LW/CW defaults
//   - localparam for the job-counter width CW+LW
//  Sub-module: pe_feed_cnt, a loadable down-counter with zero flag. One instance for pairs_left.
//  The se saturating up-counter is inline.
// TESTING
//  1. K=4 (len=3), N=2, sources always valid, no full:
//     start at cycle 2 after accept; 8 pushes in 8 consecutive cycles; max_cntr=3.
//     Drive se twice -> done pulse 1 cycle after 2nd se.
//  2. Same job, aff=1 for cycles 3-5 of STREAM:
//     no awe/bwe and no src_ready in those cycles; 8 pushes total; no data lost or reordered (scoreboard).
//  3. b_src_valid toggles 0/1 every cycle while a_src_valid=1:
//     pushes only when both valid; A words consumed in lockstep with B (4 A words -> 4 pushes).
//  4. halt=1 for 3 cycles mid-STREAM: ais=bis=1 one cycle later for 3 cycles; zero pushes while set;
//     resumes; count still 8.
//  5. N=0: accept -> DONE next cycle, done pulse; no start, no awe.
//  6. rst_n low mid-STREAM: all outputs 0 asynchronously, cmd_ready=1 after release, no done.
//     New job K=1, N=1 completes with 1 push.

Source files
------------

// File: rtl/sys_pkg.sv
// Shared definitions for the PE operand feeder: default widths, job-counter width
// and the feeder state encoding.
package sys_pkg;

  localparam int DW_DEF = 16;
  localparam int LW_DEF = 8;
  localparam int CW_DEF = 16;
  // Wide enough for N*K pairs with the largest K (2**LW) and N (2**CW - 1).
  localparam int JW_DEF = CW_DEF + LW_DEF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/pe_feeder_if.sv
// Operand link between the feeder (master) and a PE's afifo/bfifo and control inputs.
interface pe_feeder_if #(
    parameter int DW = 16,
    parameter int LW = 8
) ();

    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic          awe;
    logic          bwe;
    logic          ais;
    logic          bis;
    logic          start;
    logic [LW-1:0] max_cntr;
    logic          aff;
    logic          bff;
    logic          se;

    modport master (
        output a_in, b_in, awe, bwe, ais, bis, start, max_cntr,
        input  aff, bff, se
    );

    modport slave (
        input  a_in, b_in, awe, bwe, ais, bis, start, max_cntr,
        output aff, bff, se
    );

endinterface

// File: rtl/pe_feed_cnt.sv
// Loadable down-counter with zero flag; a load wins over a decrement.
module pe_feed_cnt #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pe_feeder.sv
// Transmit side of the PE operand interface: accepts one job, streams N*K paired
// A/B words into the PE FIFOs, then waits for N sum-end pulses before signalling done.
module pe_feeder
    import sys_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [LW-1:0] cmd_len,
    input  logic [CW-1:0] cmd_cnt,
    input  logic          a_src_valid,
    input  logic [DW-1:0] a_src_data,
    output logic          a_src_ready,
    input  logic          b_src_valid,
    input  logic [DW-1:0] b_src_data,
    output logic          b_src_ready,
    input  logic          halt,
    output logic          busy,
    output logic          done,
    pe_feeder_if.master   pe
);

    localparam int JW = CW + LW;

    feeder_state_e state_q, state_d;
    logic [LW-1:0] len_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] se_cnt_q, se_cnt_d;
    logic          halt_q;
    logic          ready_q;
    logic          accept;
    logic          push;
    logic          se_live;
    logic [JW-1:0] job_pairs;
    logic [JW-1:0] pairs_left;
    logic          pairs_zero;

    assign cmd_ready = ready_q && (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign job_pairs = JW'(cmd_cnt) * (JW'(cmd_len) + JW'(1));

    // Both FIFOs are written together or not at all, so A/B pairing can never slip.
    assign push = (state_q == ST_STREAM) && a_src_valid && b_src_valid &&
                  !pe.aff && !pe.bff && !halt_q && !pairs_zero;

    assign se_live  = pe.se && (state_q inside {ST_START, ST_STREAM, ST_WAIT});
    assign se_cnt_d = (se_live && (se_cnt_q != cnt_q)) ? se_cnt_q + CW'(1) : se_cnt_q;

    pe_feed_cnt #(.W(JW)) u_pairs (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (job_pairs),
        .dec      (push),
        .count    (pairs_left),
        .zero     (pairs_zero)
    );

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = (cmd_cnt == '0) ? ST_DONE : ST_START;
            ST_START:  state_d = ST_STREAM;
            ST_STREAM: if (push && (pairs_left == JW'(1))) state_d = ST_WAIT;
            // Looks at the post-increment count so done follows the last se by one cycle.
            ST_WAIT:   if (se_cnt_d == cnt_q) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            se_cnt_q <= '0;
            halt_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt;
            ready_q <= 1'b1;
            if (accept) begin
                len_q    <= cmd_len;
                cnt_q    <= cmd_cnt;
                se_cnt_q <= '0;
            end else begin
                se_cnt_q <= se_cnt_d;
            end
        end
    end

    assign a_src_ready  = push;
    assign b_src_ready  = push;
    assign pe.awe       = push;
    assign pe.bwe       = push;
    assign pe.a_in      = push ? a_src_data : '0;
    assign pe.b_in      = push ? b_src_data : '0;
    assign pe.ais       = halt_q && (state_q != ST_IDLE);
    assign pe.bis       = halt_q && (state_q != ST_IDLE);
    assign pe.start     = (state_q == ST_START);
    assign pe.max_cntr  = len_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_pe_feeder.sv
// Scoreboard bench for pe_feeder: jobs push expected A/B pairs into a queue, a
// monitor pops and compares on every FIFO write.
module tb_pe_feeder;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [15:0] cmd_cnt;
    logic        a_src_valid;
    logic [15:0] a_src_data;
    logic        a_src_ready;
    logic        b_src_valid;
    logic [15:0] b_src_data;
    logic        b_src_ready;
    logic        halt;
    logic        busy;
    logic        done;

    pe_feeder_if #(.DW(16), .LW(8)) pe_if ();

    pe_feeder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .cmd_cnt     (cmd_cnt),
        .a_src_valid (a_src_valid),
        .a_src_data  (a_src_data),
        .a_src_ready (a_src_ready),
        .b_src_valid (b_src_valid),
        .b_src_data  (b_src_data),
        .b_src_ready (b_src_ready),
        .halt        (halt),
        .busy        (busy),
        .done        (done),
        .pe          (pe_if.master)
    );

    always #5 clk = ~clk;

    int    checks;
    int    errors;
    pair_t exp_q[$];
    logic [15:0] a_mem [0:63];
    logic [15:0] b_mem [0:63];
    int    src_en, src_base, src_total, b_toggle, tog;
    int    a_idx, b_idx;
    int    mon_push;
    int    push_cnt, start_cnt, done_cnt;
    int    cyc, first_push, last_push;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_job(input int len, input int cnt, input int base);
        int n;
        src_base  = base;
        src_total = cnt * (len + 1);
        for (int i = 0; i < src_total; i++)
            exp_q.push_back('{a: a_mem[base+i], b: b_mem[base+i]});
        push_cnt   = 0;
        first_push = -1;
        last_push  = -1;
        src_en     = 1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1);
        cmd_len   = 8'(len);
        cmd_cnt   = 16'(cnt);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("start_after_accept", pe_if.start, (cnt != 0) ? 1 : 0);
        check("max_cntr_latched", pe_if.max_cntr, len);
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_pushes(input int target, input string name);
        int n = 0;
        while (push_cnt < target && n < 300) begin
            tick();
            n++;
        end
        check(name, push_cnt, target);
    endtask

    task automatic finish_job(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            check("no_early_done", done, 0);
            pe_if.se = 1'b1;
            tick();
        end
        pe_if.se = 1'b0;
        check("done_after_last_se", done, 1);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_ready", cmd_ready, 1);
        check("queue_drained", exp_q.size(), 0);
        src_en = 0;
        tick();
    endtask

    initial begin
        int pc, dc;
        pair_t e;
        checks = 0; errors = 0;
        for (int i = 0; i < 64; i++) begin
            a_mem[i] = 16'hA000 + 16'(i * 16'h0011);
            b_mem[i] = 16'h5000 + 16'(i * 16'h0101);
        end
        src_en = 0; src_base = 0; src_total = 0; b_toggle = 0; tog = 0;
        a_idx = 0; b_idx = 0; mon_push = 0; cyc = 0;
        push_cnt = 0; start_cnt = 0; done_cnt = 0; first_push = -1; last_push = -1;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_cnt = '0; halt = 1'b0;
        a_src_valid = 1'b0; a_src_data = '0; b_src_valid = 1'b0; b_src_data = '0;
        pe_if.aff = 1'b0; pe_if.bff = 1'b0; pe_if.se = 1'b0;

        fork
            // source driver: advances both streams on the cycle after a consumed pair
            forever begin
                @(posedge clk);
                cyc++;
                #1;
                if (src_en == 0) begin
                    a_idx = 0;
                    b_idx = 0;
                end else if (mon_push != 0) begin
                    a_idx++;
                    b_idx++;
                end
                tog = 1 - tog;
                a_src_valid = (src_en != 0) && (a_idx < src_total);
                b_src_valid = (src_en != 0) && (b_idx < src_total) && (b_toggle == 0 || tog == 1);
                a_src_data  = a_src_valid ? a_mem[src_base+a_idx] : 16'h0;
                b_src_data  = b_src_valid ? b_mem[src_base+b_idx] : 16'h0;
            end
            // monitor: compares every FIFO write against the scoreboard
            forever begin
                @(negedge clk);
                mon_push = 0;
                if (pe_if.awe || pe_if.bwe || a_src_ready || b_src_ready) begin
                    check("write_lockstep", {pe_if.awe, pe_if.bwe, a_src_ready, b_src_ready}, 4'hF);
                    check("push_conditions", {a_src_valid, b_src_valid, pe_if.aff, pe_if.bff}, 4'b1100);
                    if (exp_q.size() == 0) begin
                        check("unexpected_push", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("a_in_data", pe_if.a_in, e.a);
                        check("b_in_data", pe_if.b_in, e.b);
                    end
                    mon_push = 1;
                    push_cnt++;
                    if (first_push < 0) first_push = cyc;
                    last_push = cyc;
                end
                if (pe_if.start) start_cnt++;
                if (done) done_cnt++;
            end
            begin
                #400000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // reset state
        #3;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_outputs", {pe_if.awe, pe_if.bwe, pe_if.ais, pe_if.bis, pe_if.start, busy, done,
                              a_src_ready, b_src_ready}, 0);
        check("rst_max_cntr", pe_if.max_cntr, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", cmd_ready, 1);
        check("idle_not_busy", busy, 0);

        // 1: K=4, N=2, free-flowing sources
        start_job(3, 2, 0);
        wait_pushes(8, "t1_push_count");
        check("t1_back_to_back", last_push - first_push, 7);
        check("t1_max_cntr_hold", pe_if.max_cntr, 3);
        check("t1_busy_wait", busy, 1);
        finish_job(2);

        // 2: afifo full for three cycles mid-stream
        start_job(3, 2, 8);
        wait_pushes(2, "t2_pre_full");
        pc = push_cnt;
        pe_if.aff = 1'b1;
        tick(); tick(); tick();
        check("t2_no_push_while_full", push_cnt, pc);
        pe_if.aff = 1'b0;
        wait_pushes(8, "t2_push_count");
        finish_job(2);

        // 3: B source valid every other cycle
        b_toggle = 1;
        start_job(3, 1, 16);
        wait_pushes(4, "t3_push_count");
        finish_job(1);
        b_toggle = 0;

        // 4: halt for three cycles mid-stream
        start_job(3, 2, 20);
        wait_pushes(3, "t4_pre_halt");
        halt = 1'b1;
        tick();
        check("t4_ais_on", {pe_if.ais, pe_if.bis}, 2'b11);
        pc = push_cnt;
        tick();
        check("t4_ais_hold", {pe_if.ais, pe_if.bis}, 2'b11);
        tick();
        halt = 1'b0;
        check("t4_ais_last", {pe_if.ais, pe_if.bis}, 2'b11);
        tick();
        check("t4_ais_off", {pe_if.ais, pe_if.bis}, 2'b00);
        check("t4_no_push_in_halt", push_cnt, pc);
        wait_pushes(8, "t4_push_count");
        finish_job(2);

        // 5: N=0 goes straight to done
        start_job(5, 0, 28);
        check("t5_done_now", done, 1);
        tick();
        check("t5_done_one_cycle", done, 0);
        check("t5_no_push", push_cnt, 0);
        src_en = 0;
        tick();

        // 6: reset mid-stream, then a K=1, N=1 job
        start_job(3, 2, 28);
        wait_pushes(3, "t6_pre_reset");
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {pe_if.awe, pe_if.bwe, pe_if.ais, pe_if.bis, pe_if.start, busy, done,
                                 a_src_ready, b_src_ready, cmd_ready}, 0);
        check("t6_rst_max_cntr", pe_if.max_cntr, 0);
        src_en = 0;
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("t6_ready_after_release", cmd_ready, 1);
        check("t6_no_done_on_abort", done_cnt, dc);
        start_job(0, 1, 40);
        wait_pushes(1, "t6_push_count");
        finish_job(1);

        check("total_starts", start_cnt, 6);
        check("total_dones", done_cnt, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
